// File: rtl/model_ann_controller_h_receiver_if.sv
// Element-serial H-vector link: controller-side input stream, START/READY control,
// and the valid/ready replay stream towards the read/write heads.
interface model_ann_controller_h_receiver_if #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 4
);
    logic                    START;
    logic                    READY;
    logic [CONTROL_SIZE-1:0] SIZE_L_IN;
    logic                    H_ENABLE;
    logic                    H_IN_ENABLE;
    logic [DATA_SIZE-1:0]    H_IN;
    logic                    DATA_OUT_ENABLE;
    logic                    DATA_OUT_READY;
    logic [DATA_SIZE-1:0]    DATA_OUT;
    logic [CONTROL_SIZE-1:0] DATA_OUT_INDEX;

    // Driving side: controller plus downstream consumer.
    modport master (
        output START,
        output SIZE_L_IN,
        output H_IN_ENABLE,
        output H_IN,
        output DATA_OUT_READY,
        input  READY,
        input  H_ENABLE,
        input  DATA_OUT_ENABLE,
        input  DATA_OUT,
        input  DATA_OUT_INDEX
    );

    // The receiver itself.
    modport slave (
        input  START,
        input  SIZE_L_IN,
        input  H_IN_ENABLE,
        input  H_IN,
        input  DATA_OUT_READY,
        output READY,
        output H_ENABLE,
        output DATA_OUT_ENABLE,
        output DATA_OUT,
        output DATA_OUT_INDEX
    );
endinterface

// File: rtl/model_ann_controller_h_receiver.sv
// Buffers one H vector arriving element-serially from the ANN controller, then
// replays it in order under valid/ready and pulses READY when fully delivered.
module model_ann_controller_h_receiver #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 4,
    parameter int MAX_L_IN     = 8
) (
    input  logic CLK,
    input  logic RST,
    model_ann_controller_h_receiver_if.slave bus
);
    localparam int ADDR_W = (MAX_L_IN > 1) ? $clog2(MAX_L_IN) : 1;
    localparam logic [CONTROL_SIZE-1:0] MAX_LEN = CONTROL_SIZE'(MAX_L_IN);
    localparam logic [CONTROL_SIZE-1:0] ONE     = CONTROL_SIZE'(1);

    // Counter and length share CONTROL_SIZE bits, so the depth must leave headroom.
    generate
        if (MAX_L_IN < 1 || MAX_L_IN > (2 ** CONTROL_SIZE) - 1) begin : g_bad_depth
            $error("MAX_L_IN must lie in 1 .. 2**CONTROL_SIZE-1");
        end
    endgenerate

    typedef enum logic [1:0] {
        STARTER,
        INPUT_STATE,
        OUTPUT_STATE
    } state_t;

    state_t                  state_q, state_d;
    logic [CONTROL_SIZE-1:0] counter_q, counter_d;
    logic [CONTROL_SIZE-1:0] len_q, len_d;
    logic                    ready_q, ready_d;
    logic                    h_enable_q, h_enable_d;
    logic                    data_out_enable_q, data_out_enable_d;
    logic [DATA_SIZE-1:0]    data_out_q, data_out_d;
    logic [CONTROL_SIZE-1:0] data_out_index_q, data_out_index_d;

    logic [DATA_SIZE-1:0]    h_mem [MAX_L_IN];
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [ADDR_W-1:0]       rd_addr;
    logic [DATA_SIZE-1:0]    rd_data;
    logic [CONTROL_SIZE-1:0] next_count;
    logic [CONTROL_SIZE-1:0] size_clamped;
    logic                    last_elem;

    assign next_count   = counter_q + ONE;
    assign last_elem    = (counter_q == (len_q - ONE));
    assign size_clamped = (bus.SIZE_L_IN > MAX_LEN) ? MAX_LEN : bus.SIZE_L_IN;

    assign wr_en   = (state_q == INPUT_STATE) && bus.H_IN_ENABLE;
    assign wr_addr = counter_q[ADDR_W-1:0];
    // Output state pre-fetches the element after the current one; the input->output
    // transition fetches element 0.
    assign rd_addr = (state_q == OUTPUT_STATE) ? next_count[ADDR_W-1:0] : '0;
    // A one-element vector reads slot 0 in the same cycle it is written.
    assign rd_data = (wr_en && (wr_addr == rd_addr)) ? bus.H_IN : h_mem[rd_addr];

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            h_mem[wr_addr] <= bus.H_IN;
        end
    end

    always_comb begin
        state_d           = state_q;
        counter_d         = counter_q;
        len_d             = len_q;
        ready_d           = 1'b0;
        h_enable_d        = h_enable_q;
        data_out_enable_d = data_out_enable_q;
        data_out_d        = data_out_q;
        data_out_index_d  = data_out_index_q;

        case (state_q)
            STARTER: begin
                h_enable_d        = 1'b0;
                data_out_enable_d = 1'b0;
                if (bus.START) begin
                    len_d     = size_clamped;
                    counter_d = '0;
                    if (size_clamped == '0) begin
                        ready_d = 1'b1;
                    end else begin
                        state_d    = INPUT_STATE;
                        h_enable_d = 1'b1;
                    end
                end
            end

            INPUT_STATE: begin
                if (bus.H_IN_ENABLE) begin
                    if (last_elem) begin
                        state_d           = OUTPUT_STATE;
                        counter_d         = '0;
                        h_enable_d        = 1'b0;
                        data_out_enable_d = 1'b1;
                        data_out_d        = rd_data;
                        data_out_index_d  = '0;
                    end else begin
                        counter_d = next_count;
                    end
                end
            end

            OUTPUT_STATE: begin
                if (bus.DATA_OUT_READY) begin
                    if (last_elem) begin
                        state_d           = STARTER;
                        counter_d         = '0;
                        data_out_enable_d = 1'b0;
                        ready_d           = 1'b1;
                    end else begin
                        counter_d        = next_count;
                        data_out_d       = rd_data;
                        data_out_index_d = next_count;
                    end
                end
            end

            default: begin
                state_d           = STARTER;
                h_enable_d        = 1'b0;
                data_out_enable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q           <= STARTER;
            counter_q         <= '0;
            len_q             <= '0;
            ready_q           <= 1'b0;
            h_enable_q        <= 1'b0;
            data_out_enable_q <= 1'b0;
            data_out_q        <= '0;
            data_out_index_q  <= '0;
        end else begin
            state_q           <= state_d;
            counter_q         <= counter_d;
            len_q             <= len_d;
            ready_q           <= ready_d;
            h_enable_q        <= h_enable_d;
            data_out_enable_q <= data_out_enable_d;
            data_out_q        <= data_out_d;
            data_out_index_q  <= data_out_index_d;
        end
    end

    assign bus.READY           = ready_q;
    assign bus.H_ENABLE        = h_enable_q;
    assign bus.DATA_OUT_ENABLE = data_out_enable_q;
    assign bus.DATA_OUT        = data_out_q;
    assign bus.DATA_OUT_INDEX  = data_out_index_q;
endmodule
